pipe_hazard_ctrl: RTL

- Parametrised pipeline-control unit for the RV32I pipelined datapath. Replaces the fixed four-signal stage-load generator.
- Drives PC load and per-stage register loads for NUM_STAGES pipeline registers, where index 0 is decode and NUM_STAGES-1 is writeback.
- Tracks a valid bit per stage and applies stalls for instruction-cache and data-cache waits.
- Inserts load-use bubbles, squashes wrong-path instructions on taken branches/jumps, and keeps saturating performance counters.

---
 rtl/rv32i_types.sv | 13 +
 rtl/sat_counter.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared types for the RV32I pipelined datapath.
package rv32i_types;

  typedef enum logic [2:0] {
    RUN,
    FETCH_WAIT,
    LOAD_USE,
    REDIRECT,
    FREEZE_ALL,
    FREEZE_D
  } pipe_mode_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control: stage loads, per-stage valid bits, stall/bubble/squash
// selection and saturating performance counters.
module pipe_hazard_ctrl
  import rv32i_types::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int MEM_STAGE  = 2,
  parameter int REG_W      = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_resp,
  input  logic                  data_req_m,
  input  logic                  data_resp,
  input  logic                  redirect_m,
  input  logic                  load_ex,
  input  logic [REG_W-1:0]      rd_ex,
  input  logic [REG_W-1:0]      rs1_id,
  input  logic [REG_W-1:0]      rs2_id,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  output logic                  inst_read,
  output logic                  load_pc,
  output logic [NUM_STAGES-1:0] stage_load,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  ld_use_stall,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      bubble_cnt
);

  localparam int EX_STAGE = MEM_STAGE - 1;

  // Masks over the stage vector; a shift past the top stage yields zero,
  // so a MEM stage sitting at writeback simply has no bubble slot above it.
  localparam logic [NUM_STAGES-1:0] ONE       = NUM_STAGES'(1);
  localparam logic [NUM_STAGES-1:0] EX_BIT    = ONE << EX_STAGE;
  localparam logic [NUM_STAGES-1:0] BELOW_EX  = EX_BIT - ONE;
  localparam logic [NUM_STAGES-1:0] ABOVE_MEM = ONE << (MEM_STAGE + 1);
  localparam logic [NUM_STAGES-1:0] UPTO_MEM  = ABOVE_MEM - ONE;

  logic [NUM_STAGES-1:0] valid_d, valid_q;
  logic [NUM_STAGES-1:0] hold_mask, bubble_mask, shifted;
  logic                  imem_wait, dmem_wait, redir, lu, rs_match;
  logic                  stall_inc, flush_inc, bubble_inc;
  pipe_mode_t            mode;

  assign inst_read = !rst;
  assign imem_wait = inst_read & !inst_resp;
  assign dmem_wait = valid_q[MEM_STAGE] & data_req_m & !data_resp;
  assign redir     = valid_q[MEM_STAGE] & redirect_m;
  assign rs_match  = (rs1_used && (rs1_id == rd_ex)) || (rs2_used && (rs2_id == rd_ex));
  assign lu        = valid_q[0] & valid_q[EX_STAGE] & load_ex & (rd_ex != '0) & rs_match;

  always_comb begin
    mode = RUN;
    if (dmem_wait) begin
      mode = FREEZE_D;
    end else if (redir && imem_wait) begin
      mode = FREEZE_ALL;
    end else if (redir) begin
      mode = REDIRECT;
    end else if (lu) begin
      mode = LOAD_USE;
    end else if (imem_wait) begin
      mode = FETCH_WAIT;
    end
  end

  // hold_mask: stages that keep their contents; bubble_mask: loading stages
  // whose new valid is forced low (squash or inserted bubble).
  always_comb begin
    hold_mask   = '0;
    bubble_mask = '0;
    case (mode)
      FETCH_WAIT, LOAD_USE: begin
        hold_mask   = BELOW_EX;
        bubble_mask = EX_BIT;
      end
      REDIRECT:   bubble_mask = UPTO_MEM;
      FREEZE_ALL: hold_mask   = '1;
      FREEZE_D: begin
        hold_mask   = UPTO_MEM;
        bubble_mask = ABOVE_MEM;
      end
      default: begin
        hold_mask   = '0;
        bubble_mask = '0;
      end
    endcase
  end

  assign shifted = {valid_q[NUM_STAGES-2:0], 1'b1};

  always_comb begin
    if (rst) begin
      valid_d = '0;
    end else begin
      valid_d = ((~hold_mask & shifted) | (hold_mask & valid_q)) & ~bubble_mask;
    end
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
  end

  assign stage_valid  = valid_q;
  assign stage_load   = rst ? '0 : ~hold_mask;
  assign load_pc      = !rst && ((mode == RUN) || (mode == REDIRECT));
  assign ld_use_stall = !rst && (mode == LOAD_USE);

  assign stall_inc  = !rst && ((mode == FREEZE_D) || (mode == FREEZE_ALL) ||
                               (mode == LOAD_USE) || (mode == FETCH_WAIT));
  assign flush_inc  = !rst && (mode == REDIRECT);
  assign bubble_inc = !rst && (((mode == FETCH_WAIT) || (mode == LOAD_USE)) ||
                               ((mode == FREEZE_D) && (ABOVE_MEM != '0)));

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (bubble_inc),
    .count (bubble_cnt)
  );

endmodule
